// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register with an optional skid entry, hold/flush control
// and saturating stall/flush counters for performance debug.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W   = 160,
    parameter bit          SKID_EN  = 1'b1,
    parameter bit          CLR_DATA = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              stg_clk,
    input  logic              reset_n,
    input  logic              stg_ena,
    input  logic              stg_x,
    input  logic              cnt_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic m_valid, s_valid, live, in_acc, out_acc;

    assign m_valid = (state_q != EMPTY);
    assign s_valid = (state_q == TWO);
    assign live    = reset_n & ~stg_ena & ~stg_x;

    assign out_valid = m_valid & live;
    // With the skid entry, in_ready comes from state only, breaking the ready path.
    assign in_ready  = SKID_EN ? (~s_valid & live) : ((~m_valid | out_ready) & live);

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (stg_x) begin
            state_d = EMPTY;
            if (CLR_DATA) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (!stg_ena) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_acc) begin
                        state_d  = ONE;
                        m_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        m_data_d = in_data;
                    end else if (in_acc && SKID_EN) begin
                        state_d  = TWO;
                        s_data_d = in_data;
                    end else if (out_acc) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_acc) begin
                        state_d  = ONE;
                        m_data_d = s_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (m_valid && !out_acc && !stg_x && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (stg_x && (m_valid || s_valid) && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge stg_clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            m_data_q    <= '0;
            s_data_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
